// File: rtl/midi_pkg.sv
// -----------------------------------------------------------------------------
// midi_pkg
//   Shared definitions for the MIDI note decoder and its period ROM.
//   - Status-nibble and controller constants used by the channel-voice parser.
//   - Parser state and pipeline event enums.
//   - note_half_period(): elaboration-time computation of one table entry,
//       round(clk_hz / (2 * 440 * 2^((note-69)/12))).
// -----------------------------------------------------------------------------
package midi_pkg;

  localparam int SETPOINT_W = 22;

  // Upper nibble of a channel-voice status byte.
  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] CC       = 4'hB;
  localparam logic [3:0] PROG     = 4'hC;
  localparam logic [3:0] CHPRESS  = 4'hD;

  localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;

  typedef enum logic [1:0] {
    IDLE,
    D1,
    D2
  } parse_state_t;

  typedef enum logic [1:0] {
    EV_NOTE_ON,
    EV_NOTE_OFF,
    EV_ALL_OFF
  } event_kind_t;

  // 2^(1/12)
  localparam real SEMITONE_RATIO = 1.0594630943592953;

  // The exponent (note-69)/12 is split into whole octaves (exact powers of
  // two) plus 0..11 semitones, so at most 11 multiplies by the semitone
  // ratio are needed and the rounding error stays far below 0.5 count.
  function automatic logic [SETPOINT_W-1:0] note_half_period(input int clk_hz,
                                                             input int note_num);
    int  rel;
    int  oct;
    int  semi;
    real freq;
    rel  = note_num - 69 + 120;  // offset keeps the division non-negative
    oct  = rel / 12 - 10;
    semi = rel % 12;
    freq = 440.0;
    for (int i = 0; i < semi; i++) freq = freq * SEMITONE_RATIO;
    if (oct >= 0) begin
      for (int i = 0; i < oct; i++) freq = freq * 2.0;
    end else begin
      for (int i = 0; i < -oct; i++) freq = freq * 0.5;
    end
    return SETPOINT_W'($rtoi(real'(clk_hz) / (2.0 * freq) + 0.5));
  endfunction

endpackage

// File: rtl/note_period_rom.sv
// -----------------------------------------------------------------------------
// note_period_rom
//   128-entry constant table of half-period counts (one per MIDI note),
//   built at elaboration from CLK_HZ, with a one-cycle registered read.
//   Ports:
//     clk    system clock
//     rst    asynchronous active-high reset (clears the output register)
//     rd_en  load the output register from the table this cycle
//     addr   MIDI note number
//     data   registered half-period count; holds when rd_en=0
// -----------------------------------------------------------------------------
module note_period_rom
  import midi_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_en,
  input  logic [6:0]            addr,
  output logic [SETPOINT_W-1:0] data
);

  logic [SETPOINT_W-1:0] period_tbl [128];

  for (genvar i = 0; i < 128; i++) begin : g_tbl
    assign period_tbl[i] = note_half_period(CLK_HZ, i);
  end

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values regardless of process ordering.
  // NOTE: the table itself is constant and needs no reset; only the output
  // register is reset so the setpoint reads 0 before the first note.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= '0;
    end else if (rd_en) begin
      data <= period_tbl[addr];
    end
  end

endmodule

// File: rtl/midi_note_decoder.sv
// -----------------------------------------------------------------------------
// midi_note_decoder
//   Monophonic MIDI channel-voice parser for one floppy drive. Filters one
//   channel, tracks Note On / Note Off with last-note priority and drives the
//   stepper's half-period setpoint and enable.
//   Ports:
//     clk          system clock
//     rst          asynchronous active-high reset
//     rx_data      received MIDI byte, valid when rx_new_data=1
//     rx_new_data  one-cycle strobe per received byte (may be back-to-back)
//     setpoint     half-period in clk cycles of the current/last note
//     enable       1 while a note is sounding
//     note         MIDI note number currently or last sounded
//   Pipeline: completing byte in cycle k -> event register (end of k) ->
//   outputs and ROM data register (end of k+1).
// -----------------------------------------------------------------------------
module midi_note_decoder
  import midi_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int CHANNEL = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_new_data,
  output logic [SETPOINT_W-1:0] setpoint,
  output logic                  enable,
  output logic [6:0]            note
);

  localparam logic [3:0] MY_CH = CHANNEL[3:0];

  // Parser state; rs_q[7]=0 means no valid running status.
  parse_state_t state_q, state_d;
  logic [7:0]   rs_q, rs_d;
  logic [6:0]   d1_q, d1_d;

  logic         msg_done;
  logic [6:0]   msg_d1;
  logic [6:0]   msg_d2;
  logic         two_byte;

  // Stage-1 event register.
  logic         ev_valid_d, ev_valid_q;
  event_kind_t  ev_kind_d,  ev_kind_q;
  logic [6:0]   ev_note_d,  ev_note_q;

  logic         rom_rd;

  // ---------------------------------------------------------------------------
  // Parser next-state
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned here gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    rs_d     = rs_q;
    d1_d     = d1_q;
    msg_done = 1'b0;
    msg_d1   = d1_q;
    msg_d2   = '0;
    two_byte = !((rs_q[7:4] == PROG) || (rs_q[7:4] == CHPRESS));

    if (rx_new_data) begin
      if (rx_data[7:3] == 5'b11111) begin
        // Realtime (F8-FF): invisible to the parser.
      end else if (rx_data[7:4] == 4'hF) begin
        // System common/exclusive: drop running status, ignore data until
        // the next status byte.
        rs_d    = '0;
        state_d = IDLE;
      end else if (rx_data[7]) begin
        // Channel voice status: aborts any partial message.
        rs_d    = rx_data;
        state_d = D1;
      end else begin
        unique case (state_q)
          IDLE, D1: begin
            // In IDLE a data byte only counts under valid running status,
            // and is then handled exactly like a first data byte.
            if ((state_q == D1) || rs_q[7]) begin
              if (two_byte) begin
                d1_d    = rx_data[6:0];
                state_d = D2;
              end else begin
                msg_done = 1'b1;
                msg_d1   = rx_data[6:0];
                state_d  = D1;
              end
            end
          end
          D2: begin
            msg_done = 1'b1;
            msg_d1   = d1_q;
            msg_d2   = rx_data[6:0];
            state_d  = D1;
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rs_q    <= '0;
      d1_q    <= '0;
    end else begin
      state_q <= state_d;
      rs_q    <= rs_d;
      d1_q    <= d1_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Event decode (this channel only; other channels were framed and dropped)
  // ---------------------------------------------------------------------------
  always_comb begin
    ev_valid_d = 1'b0;
    ev_kind_d  = EV_NOTE_OFF;
    ev_note_d  = msg_d1;
    if (msg_done && (rs_q[3:0] == MY_CH)) begin
      unique case (rs_q[7:4])
        NOTE_ON: begin
          ev_valid_d = 1'b1;
          ev_kind_d  = (msg_d2 != '0) ? EV_NOTE_ON : EV_NOTE_OFF;
        end
        NOTE_OFF: begin
          ev_valid_d = 1'b1;
          ev_kind_d  = EV_NOTE_OFF;
        end
        CC: begin
          if (msg_d1 == CC_ALL_NOTES_OFF) begin
            ev_valid_d = 1'b1;
            ev_kind_d  = EV_ALL_OFF;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ev_valid_q <= 1'b0;
      ev_kind_q  <= EV_NOTE_OFF;
      ev_note_q  <= '0;
    end else begin
      ev_valid_q <= ev_valid_d;
      ev_kind_q  <= ev_kind_d;
      ev_note_q  <= ev_note_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: ROM read for Note On, and note/enable update in the same cycle
  // ---------------------------------------------------------------------------
  assign rom_rd = ev_valid_q && (ev_kind_q == EV_NOTE_ON);

  note_period_rom #(
    .CLK_HZ (CLK_HZ)
  ) u_rom (
    .clk   (clk),
    .rst   (rst),
    .rd_en (rom_rd),
    .addr  (ev_note_q),
    .data  (setpoint)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable <= 1'b0;
      note   <= '0;
    end else if (ev_valid_q) begin
      unique case (ev_kind_q)
        EV_NOTE_ON: begin
          // Last-note priority: a new Note On always takes over.
          note   <= ev_note_q;
          enable <= 1'b1;
        end
        EV_NOTE_OFF: begin
          // Releasing an older, already replaced note must not silence.
          if (enable && (ev_note_q == note)) enable <= 1'b0;
        end
        EV_ALL_OFF: enable <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_midi_note_decoder.sv
// -----------------------------------------------------------------------------
// tb_midi_note_decoder
//   Scoreboard bench: every byte sent updates a behavioural MIDI model and
//   pushes the expected outputs, due two cycles after the strobe; each tick
//   pops and compares due entries. Scenario tasks also check spec constants.
// -----------------------------------------------------------------------------
module tb_midi_note_decoder;

  localparam int CLK_HZ  = 50_000_000;
  localparam int CHANNEL = 0;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_new_data;
  logic [21:0] setpoint;
  logic        enable;
  logic [6:0]  note;

  always #5 clk = ~clk;

  midi_note_decoder #(
    .CLK_HZ  (CLK_HZ),
    .CHANNEL (CHANNEL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_new_data (rx_new_data),
    .setpoint    (setpoint),
    .enable      (enable),
    .note        (note)
  );

  typedef struct {
    int          due;
    logic [21:0] sp;
    logic        en;
    logic [6:0]  nt;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   checks;
  int   failures;

  // Behavioural model state.
  logic [7:0]  m_rs;
  int          m_state;  // 0 idle, 1 expecting d1, 2 expecting d2
  logic [6:0]  m_d1;
  logic        m_en;
  logic [6:0]  m_note;
  logic [21:0] m_sp;

  function automatic logic [21:0] ref_period(input int n);
    real f;
    f = 440.0 * $pow(2.0, (real'(n) - 69.0) / 12.0);
    return 22'($rtoi(real'(CLK_HZ) / (2.0 * f) + 0.5));
  endfunction

  task automatic model_reset();
    m_rs = 8'h00; m_state = 0; m_d1 = '0;
    m_en = 1'b0; m_note = '0; m_sp = '0;
  endtask

  task automatic model_msg(input logic [6:0] d1, input logic [6:0] d2);
    if (m_rs[3:0] == 4'(CHANNEL)) begin
      if ((m_rs[7:4] == 4'h9) && (d2 != 0)) begin
        m_note = d1; m_sp = ref_period(int'(d1)); m_en = 1'b1;
      end else if ((m_rs[7:4] == 4'h9) || (m_rs[7:4] == 4'h8)) begin
        if (m_en && (d1 == m_note)) m_en = 1'b0;
      end else if ((m_rs[7:4] == 4'hB) && (d1 == 7'd123)) begin
        m_en = 1'b0;
      end
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b >= 8'hF8) begin
      // realtime: nothing
    end else if (b >= 8'hF0) begin
      m_rs = 8'h00; m_state = 0;
    end else if (b[7]) begin
      m_rs = b; m_state = 1;
    end else if (m_state == 2) begin
      model_msg(m_d1, b[6:0]);
      m_state = 1;
    end else if ((m_state == 1) || m_rs[7]) begin
      if ((m_rs[7:4] == 4'hC) || (m_rs[7:4] == 4'hD)) begin
        model_msg(b[6:0], 7'd0);
        m_state = 1;
      end else begin
        m_d1 = b[6:0];
        m_state = 2;
      end
    end
  endtask

  // One clock: advance, then compare every scoreboard entry due now.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (setpoint !== e.sp || enable !== e.en || note !== e.nt) begin
        failures++;
        $display("FAIL sb cyc=%0d got sp=%0d en=%0b note=%0d expected sp=%0d en=%0b note=%0d",
                 cyc, setpoint, enable, note, e.sp, e.en, e.nt);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    exp_t e;
    rx_data     = b;
    rx_new_data = 1'b1;
    model_byte(b);
    e.due = cyc + 2; e.sp = m_sp; e.en = m_en; e.nt = m_note;
    sb.push_back(e);
    tick();
    rx_new_data = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_data = '0; rx_new_data = 1'b0;
    model_reset();
    @(negedge clk); @(negedge clk);
    checks++;
    if (setpoint !== 22'd0 || enable !== 1'b0 || note !== 7'd0) begin
      failures++;
      $display("FAIL reset got sp=%0d en=%0b note=%0d expected 0/0/0", setpoint, enable, note);
    end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_basic();
    send_byte(8'h90); send_byte(8'h45); send_byte(8'h64);
    idle(3);
    checks++;
    if (enable !== 1'b1 || note !== 7'd69 || setpoint !== 22'd56818) begin
      failures++;
      $display("FAIL basic_a4 got sp=%0d en=%0b note=%0d expected 56818/1/69", setpoint, enable, note);
    end
  endtask

  task automatic test_running_status();
    send_byte(8'h90); send_byte(8'h3C); send_byte(8'h40);
    send_byte(8'h40); send_byte(8'h40);
    idle(3);
    checks++;
    if (enable !== 1'b1 || note !== 7'd64 || setpoint !== 22'd75843) begin
      failures++;
      $display("FAIL running_on got sp=%0d en=%0b note=%0d expected 75843/1/64", setpoint, enable, note);
    end
    send_byte(8'h40); send_byte(8'h00);
    idle(3);
    checks++;
    if (enable !== 1'b0 || setpoint !== 22'd75843) begin
      failures++;
      $display("FAIL running_off got sp=%0d en=%0b expected 75843/0", setpoint, enable);
    end
  endtask

  task automatic test_last_note();
    send_byte(8'h90); send_byte(8'h3C); send_byte(8'h40);
    send_byte(8'h40); send_byte(8'h40);
    send_byte(8'h80); send_byte(8'h3C); send_byte(8'h00);
    idle(3);
    checks++;
    if (enable !== 1'b1 || note !== 7'd64) begin
      failures++;
      $display("FAIL last_note_hold got en=%0b note=%0d expected 1/64", enable, note);
    end
    send_byte(8'h40); send_byte(8'h7F);
    idle(3);
    checks++;
    if (enable !== 1'b0) begin
      failures++;
      $display("FAIL last_note_off got en=%0b expected 0", enable);
    end
  endtask

  task automatic test_filtering();
    send_byte(8'h91); send_byte(8'h45); send_byte(8'h64);
    idle(3);
    checks++;
    if (enable !== 1'b0) begin
      failures++;
      $display("FAIL other_channel got en=%0b expected 0", enable);
    end
    send_byte(8'h90); send_byte(8'h45); send_byte(8'hF8); send_byte(8'h64);
    idle(3);
    checks++;
    if (enable !== 1'b1 || note !== 7'd69 || setpoint !== 22'd56818) begin
      failures++;
      $display("FAIL realtime_gap got sp=%0d en=%0b note=%0d expected 56818/1/69", setpoint, enable, note);
    end
    send_byte(8'h90); send_byte(8'h3C); send_byte(8'hF0); send_byte(8'h64);
    idle(3);
    checks++;
    if (note !== 7'd69 || setpoint !== 22'd56818) begin
      failures++;
      $display("FAIL sysex_abort got sp=%0d note=%0d expected 56818/69", setpoint, note);
    end
  endtask

  task automatic test_all_off();
    send_byte(8'h90); send_byte(8'h3C); send_byte(8'h50);
    send_byte(8'hC0); send_byte(8'h05);
    idle(3);
    checks++;
    if (enable !== 1'b1 || note !== 7'd60) begin
      failures++;
      $display("FAIL prog_change got en=%0b note=%0d expected 1/60", enable, note);
    end
    send_byte(8'hB0); send_byte(8'h7B); send_byte(8'h00);
    idle(3);
    checks++;
    if (enable !== 1'b0 || note !== 7'd60) begin
      failures++;
      $display("FAIL all_off got en=%0b note=%0d expected 0/60", enable, note);
    end
  endtask

  task automatic test_boundaries();
    send_byte(8'h90); send_byte(8'h00); send_byte(8'h7F);
    idle(3);
    checks++;
    if (setpoint !== 22'd3057805 || note !== 7'd0 || enable !== 1'b1) begin
      failures++;
      $display("FAIL note0 got sp=%0d note=%0d en=%0b expected 3057805/0/1", setpoint, note, enable);
    end
    // Back-to-back: on 127 immediately followed by off 127.
    send_byte(8'h7F); send_byte(8'h01); send_byte(8'h7F); send_byte(8'h00);
    idle(3);
    checks++;
    if (setpoint !== 22'd1993 || note !== 7'd127 || enable !== 1'b0) begin
      failures++;
      $display("FAIL note127 got sp=%0d note=%0d en=%0b expected 1993/127/0", setpoint, note, enable);
    end
  endtask

  task automatic test_random();
    logic [7:0] pool [12];
    pool = '{8'h90, 8'h80, 8'hB0, 8'hC0, 8'hD0, 8'hE0, 8'h91, 8'hF8, 8'hF0,
             8'h3C, 8'h40, 8'h00};
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 2) == 0) send_byte(pool[$urandom_range(0, 11)]);
      else if ($urandom_range(0, 5) == 0) send_byte(8'd123);
      else if ($urandom_range(0, 3) == 0) idle(1);
      else send_byte(8'($urandom_range(40, 80)));
    end
    idle(3);
  endtask

  task automatic test_reset_mid();
    send_byte(8'h90); send_byte(8'h3C); send_byte(8'h40);
    send_byte(8'h90); send_byte(8'h45);
    #2 rst = 1'b1;
    sb.delete();
    model_reset();
    #1;
    checks++;
    if (setpoint !== 22'd0 || enable !== 1'b0 || note !== 7'd0) begin
      failures++;
      $display("FAIL async_reset got sp=%0d en=%0b note=%0d expected 0/0/0", setpoint, enable, note);
    end
    @(negedge clk); rst = 1'b0;
    send_byte(8'h64);
    idle(3);
    checks++;
    if (setpoint !== 22'd0 || enable !== 1'b0 || note !== 7'd0) begin
      failures++;
      $display("FAIL reset_mid_msg got sp=%0d en=%0b note=%0d expected 0/0/0", setpoint, enable, note);
    end
  endtask

  initial begin
    cyc = 0; checks = 0; failures = 0;
    test_reset();
    test_basic();
    test_running_status();
    test_last_note();
    test_filtering();
    test_all_off();
    test_boundaries();
    test_random();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain got %0d pending expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout reached expected finish");
    $fatal(1);
  end

endmodule
